uart_tx_param: RTL and testbench

Parametrised UART transmitter combining frame control, serialisation, parity generation and a one-deep holding buffer in a single block. Frames are `DATA_WIDTH` bits, with optional even/odd parity and one or two stop bits selected per frame. Bit timing is set by an external baud-rate enable `TICK`. The block sits between the system-side byte producer (valid/ready handshake) and the serial line pin.

---
 rtl/uart_tx_pkg.sv | 31 +++
 rtl/uart_tx_param_if.sv | 29 ++
 rtl/uart_tx_serializer.sv | 52 +++++
 rtl/uart_tx_param.sv | 139 +++++++++++++
 tb/tb_uart_tx_param.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared types and constants for the parametrised UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STR    = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STP1   = 3'd4,
        STP2   = 3'd5
    } state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Wide enough to count the largest legal frame (9 data bits)
    localparam int CNT_W = $clog2(9);

    function automatic logic parity_bit(input logic xor_red, input logic par_typ);
        return xor_red ^ (par_typ == ODD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_param_if.sv
// ============================================================================
// Module   : uart_tx_param_if
// Brief    : Producer-side valid/ready bus with per-frame format settings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STP_2;
    logic                  Ready;

    modport master (
        output P_DATA, Data_valid, PAR_EN, PAR_TYP, STP_2,
        input  Ready
    );

    modport slave (
        input  P_DATA, Data_valid, PAR_EN, PAR_TYP, STP_2,
        output Ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : LSB-first shift register with data-bit counter for the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    input  wire logic                  load,
    input  wire logic                  clear,
    input  wire logic                  shift,
    input  wire logic [DATA_WIDTH-1:0] load_data,
    output logic                       cur_bit,
    output logic                       next_bit,
    output logic                       last
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= load_data;
            r_cnt   <= '0;
        end else begin
            if (clear) begin
                r_cnt <= '0;
            end
            if (shift) begin
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    // next_bit is what lands on the line once the current bit has been shifted out
    assign cur_bit  = r_shift[0];
    assign next_bit = r_shift[1];
    assign last     = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/uart_tx_param.sv
// ============================================================================
// Module   : uart_tx_param
// Brief    : Parametrised UART transmitter with parity, 1/2 stop bits and a
//            one-deep holding register in front of the serialiser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    input  wire logic       TICK,
    uart_tx_param_if.slave  bus,
    output logic            TX_OUT,
    output logic            Busy
);

    state_t                r_state;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_par_en;
    logic                  r_hold_par_typ;
    logic                  r_hold_stp2;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stp2;

    logic w_frame_end;
    logic w_drain;
    logic w_accept;
    logic w_shift;
    logic w_clear;
    logic w_cur_bit;
    logic w_next_bit;
    logic w_last;

    assign w_frame_end = ((r_state == STP1) && !r_stp2) || (r_state == STP2);
    assign w_drain     = TICK && r_hold_full && ((r_state == IDLE) || w_frame_end);
    assign w_accept    = bus.Data_valid && !r_hold_full;
    assign w_shift     = TICK && (r_state == DATA) && !w_last;
    assign w_clear     = TICK && (r_state == STR);

    assign bus.Ready = !r_hold_full;
    assign Busy      = (r_state != IDLE) || r_hold_full;

    // Accept and drain are mutually exclusive since accept needs an empty register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hold_full    <= 1'b0;
            r_hold_data    <= '0;
            r_hold_par_en  <= 1'b0;
            r_hold_par_typ <= EVEN;
            r_hold_stp2    <= 1'b0;
        end else if (w_accept) begin
            r_hold_full    <= 1'b1;
            r_hold_data    <= bus.P_DATA;
            r_hold_par_en  <= bus.PAR_EN;
            r_hold_par_typ <= bus.PAR_TYP;
            r_hold_stp2    <= bus.STP_2;
        end else if (w_drain) begin
            r_hold_full    <= 1'b0;
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (w_drain),
        .clear     (w_clear),
        .shift     (w_shift),
        .load_data (r_hold_data),
        .cur_bit   (w_cur_bit),
        .next_bit  (w_next_bit),
        .last      (w_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            TX_OUT   <= 1'b1;
            r_par_en <= 1'b0;
            r_par_bit <= 1'b0;
            r_stp2   <= 1'b0;
        end else if (TICK) begin
            if ((r_state == IDLE) || w_frame_end) begin
                // Frame settings are latched here so producer changes mid-frame are ignored
                if (r_hold_full) begin
                    r_par_en  <= r_hold_par_en;
                    r_stp2    <= r_hold_stp2;
                    r_par_bit <= parity_bit(^r_hold_data, r_hold_par_typ);
                    TX_OUT    <= 1'b0;
                    r_state   <= STR;
                end else begin
                    TX_OUT    <= 1'b1;
                    r_state   <= IDLE;
                end
            end else begin
                case (r_state)
                    STR: begin
                        TX_OUT  <= w_cur_bit;
                        r_state <= DATA;
                    end
                    DATA: begin
                        if (!w_last) begin
                            TX_OUT <= w_next_bit;
                        end else if (r_par_en) begin
                            TX_OUT  <= r_par_bit;
                            r_state <= PARITY;
                        end else begin
                            TX_OUT  <= 1'b1;
                            r_state <= STP1;
                        end
                    end
                    PARITY: begin
                        TX_OUT  <= 1'b1;
                        r_state <= STP1;
                    end
                    STP1: begin
                        TX_OUT  <= 1'b1;
                        r_state <= STP2;
                    end
                    default: begin
                        TX_OUT  <= 1'b1;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// ============================================================================
// Module   : tb_uart_tx_param
// Brief    : Directed self-checking bench for uart_tx_param (8- and 5-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_param;

    logic CLK   = 1'b0;
    logic RST   = 1'b0;
    logic tick8 = 1'b0;
    logic tick5 = 1'b0;
    logic tx8, busy8, tx5, busy5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] acc_q[$];

    bit exp_a5  [11] = '{0,1,0,1,0,0,1,0,1,0,1};
    bit exp_01  [12] = '{0,1,0,0,0,0,0,0,0,0,1,1};
    bit exp_b2b [21] = '{0,0,0,1,1,1,1,0,0,1,0,1,1,0,0,0,0,1,1,1,1};
    bit exp_15  [7]  = '{0,1,0,1,0,1,1};

    always #5 CLK = ~CLK;

    uart_tx_param_if #(.DATA_WIDTH(8)) bus8 ();
    uart_tx_param_if #(.DATA_WIDTH(5)) bus5 ();

    uart_tx_param #(.DATA_WIDTH(8)) u_dut8 (
        .CLK    (CLK),
        .RST    (RST),
        .TICK   (tick8),
        .bus    (bus8),
        .TX_OUT (tx8),
        .Busy   (busy8)
    );

    uart_tx_param #(.DATA_WIDTH(5)) u_dut5 (
        .CLK    (CLK),
        .RST    (RST),
        .TICK   (tick5),
        .bus    (bus5),
        .TX_OUT (tx5),
        .Busy   (busy5)
    );

    // Scoreboard of words actually taken by the 8-bit instance
    always @(posedge CLK) begin
        if (bus8.Data_valid && bus8.Ready) begin
            acc_q.push_back(bus8.P_DATA);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge CLK);
    endtask

    task automatic run_a5(input string pfx);
        tick8           = 1'b1;
        bus8.P_DATA     = 8'hA5;
        bus8.PAR_EN     = 1'b1;
        bus8.PAR_TYP    = 1'b0;
        bus8.STP_2      = 1'b0;
        bus8.Data_valid = 1'b1;
        check_eq({pfx, "_ready_pre"}, 32'(bus8.Ready), 32'd1);
        step();
        bus8.Data_valid = 1'b0;
        check_eq({pfx, "_ready_acc"}, 32'(bus8.Ready), 32'd0);
        check_eq({pfx, "_busy_acc"}, 32'(busy8), 32'd1);
        check_eq({pfx, "_tx_acc"}, 32'(tx8), 32'd1);
        for (int i = 0; i < 11; i++) begin
            step();
            check_eq($sformatf("%s_bit%0d", pfx, i), 32'(tx8), 32'(exp_a5[i]));
            if (i == 0) check_eq({pfx, "_ready_drain"}, 32'(bus8.Ready), 32'd1);
            if (i == 10) check_eq({pfx, "_busy_stop"}, 32'(busy8), 32'd1);
        end
        step();
        check_eq({pfx, "_tx_idle"}, 32'(tx8), 32'd1);
        check_eq({pfx, "_busy_idle"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        logic cur;
        bus8.P_DATA = '0; bus8.Data_valid = 1'b0; bus8.PAR_EN = 1'b0;
        bus8.PAR_TYP = 1'b0; bus8.STP_2 = 1'b0;
        bus5.P_DATA = '0; bus5.Data_valid = 1'b0; bus5.PAR_EN = 1'b0;
        bus5.PAR_TYP = 1'b0; bus5.STP_2 = 1'b0;

        // Reset state
        #12;
        check_eq("rst_tx8", 32'(tx8), 32'd1);
        check_eq("rst_ready8", 32'(bus8.Ready), 32'd1);
        check_eq("rst_busy8", 32'(busy8), 32'd0);
        check_eq("rst_tx5", 32'(tx5), 32'd1);
        check_eq("rst_ready5", 32'(bus5.Ready), 32'd1);
        check_eq("rst_busy5", 32'(busy5), 32'd0);
        step();
        RST = 1'b1;
        step();

        // Even parity, TICK every cycle
        run_a5("a5");

        // Odd parity, two stop bits, one TICK per 16 cycles; settings change mid-frame
        tick8           = 1'b0;
        bus8.P_DATA     = 8'h01;
        bus8.PAR_EN     = 1'b1;
        bus8.PAR_TYP    = 1'b1;
        bus8.STP_2      = 1'b1;
        bus8.Data_valid = 1'b1;
        step();
        bus8.Data_valid = 1'b0;
        bus8.PAR_EN     = 1'b0;
        bus8.PAR_TYP    = 1'b0;
        bus8.STP_2      = 1'b0;
        cur = 1'b1;
        for (int k = 0; k < 13; k++) begin
            for (int c = 0; c < 16; c++) begin
                tick8 = (c == 15);
                step();
                if (c == 15) cur = (k < 12) ? exp_01[k] : 1'b1;
                check_eq($sformatf("slow_p%0d_c%0d", k, c), 32'(tx8), 32'(cur));
            end
        end
        tick8 = 1'b0;
        check_eq("slow_busy_idle", 32'(busy8), 32'd0);

        // Back-to-back frames with Data_valid held; second word collides with drain
        acc_q.delete();
        tick8           = 1'b1;
        bus8.P_DATA     = 8'h3C;
        bus8.PAR_EN     = 1'b0;
        bus8.STP_2      = 1'b0;
        bus8.Data_valid = 1'b1;
        step();
        bus8.P_DATA = 8'hC3;
        check_eq("b2b_ready_full", 32'(bus8.Ready), 32'd0);
        for (int i = 0; i < 21; i++) begin
            step();
            check_eq($sformatf("b2b_bit%0d", i), 32'(tx8), 32'(exp_b2b[i]));
            if (i == 0) check_eq("coll_not_taken", 32'(bus8.Ready), 32'd1);
            if (i == 1) begin
                check_eq("coll_taken", 32'(bus8.Ready), 32'd0);
                bus8.Data_valid = 1'b0;
            end
        end
        check_eq("b2b_busy_idle", 32'(busy8), 32'd0);
        check_eq("sb_count", 32'(acc_q.size()), 32'd2);
        for (int i = 0; i < acc_q.size() && i < 2; i++) begin
            check_eq($sformatf("sb_word%0d", i), 32'(acc_q[i]), (i == 0) ? 32'h3C : 32'hC3);
        end

        // Reset in the middle of the data bits
        bus8.P_DATA     = 8'h00;
        bus8.Data_valid = 1'b1;
        step();
        bus8.Data_valid = 1'b0;
        repeat (4) step();
        check_eq("rst_mid_tx_pre", 32'(tx8), 32'd0);
        check_eq("rst_mid_busy_pre", 32'(busy8), 32'd1);
        #2 RST = 1'b0;
        #1;
        check_eq("rst_mid_tx", 32'(tx8), 32'd1);
        check_eq("rst_mid_ready", 32'(bus8.Ready), 32'd1);
        check_eq("rst_mid_busy", 32'(busy8), 32'd0);
        step();
        RST = 1'b1;
        run_a5("post_rst");

        // Narrow 5-bit build
        tick5           = 1'b1;
        bus5.P_DATA     = 5'h15;
        bus5.PAR_EN     = 1'b0;
        bus5.STP_2      = 1'b0;
        bus5.Data_valid = 1'b1;
        step();
        bus5.Data_valid = 1'b0;
        check_eq("w5_busy_acc", 32'(busy5), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq($sformatf("w5_bit%0d", i), 32'(tx5), 32'(exp_15[i]));
        end
        step();
        check_eq("w5_tx_idle", 32'(tx5), 32'd1);
        check_eq("w5_busy_idle", 32'(busy5), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
